counter_nch: RTL and testbench
==============================

# counter_nch

Parametrised multi-channel synchronous counter bank. It is the next generation of the fixed 4-bit free-running counters in the register micro-benchmarks. It provides CHANNELS independent counters of WIDTH bits on one clock, with per-channel enable, direction, synchronous clear, parallel load, programmable modulo, registered wrap pulses and sticky overflow flags. An optional cascade mode chains the channels into one wide ripple-carry counter, which gives the benchmark suite a deeper carry/enable structure to map.

## Interface
- WIDTH, 4, bits per channel (≥2)
- CHANNELS, 2, number of counter channels (≥1)
- MAX_VAL, 2**WIDTH-1, terminal count; channel range is 0..MAX_VAL (1 ≤ MAX_VAL ≤ 2**WIDTH-1)
- CASCADE, 0, 1 = channel i>0 advances only on a wrap event of channel i-1
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  CHANNELS  per-channel count enable
- up_dn  in  CHANNELS  1 = count up, 0 = count down
- clr  in  CHANNELS  per-channel synchronous clear to 0
- load  in  CHANNELS  per-channel parallel load
- load_val  in  CHANNELS*WIDTH  load data; channel i at bits [i*WIDTH +: WIDTH]
- ovf_clr  in  CHANNELS  clear sticky overflow flag
- q  out  CHANNELS*WIDTH  counter values; channel i at [i*WIDTH +: WIDTH]
- wrap  out  CHANNELS  registered one-cycle pulse: channel wrapped on the previous edge
- ovf  out  CHANNELS  sticky: channel has wrapped since last clear

## Operation
- Priority per channel, evaluated every rising edge: rst low > clr > load > count > hold.
- rst low: all q = 0, wrap = 0, ovf = 0, regardless of other inputs.
- clr: q[i] = 0, wrap[i] = 0, ovf[i] = 0.
- load: q[i] = min(load_val[i], MAX_VAL). Out-of-range load values saturate to MAX_VAL. wrap[i] = 0; ovf[i] unchanged unless ovf_clr[i].
- Count: the effective enable eff[i] gates the step.
  - eff[i] = en[i], except when CASCADE=1 and i>0, where eff[i] = en[i] & wev[i-1].
  - wev[i] is the combinational wrap event of channel i this cycle: eff[i] & no clr/load & ((up and q==MAX_VAL) or (down and q==0)).
- Up: q==MAX_VAL → 0, otherwise q+1. Down: q==0 → MAX_VAL, otherwise q-1.
- wrap[i] register = wev[i]. It is 1 for exactly one cycle per wrap.
- ovf[i] is set when wev[i]. When ovf_clr[i] and wev[i] occur in the same cycle, the set wins (ovf = 1). Otherwise ovf_clr[i] clears the flag.
- Arithmetic is WIDTH-bit modulo (MAX_VAL+1). q never exceeds MAX_VAL after reset.
- CASCADE=1, all en high, all up: the channels form one counter of radix (MAX_VAL+1)^CHANNELS. Carries ripple through every channel in the same edge, with no per-stage delay.
- A clr or load on channel i-1 suppresses wev[i-1], so channel i does not advance in that cycle.
- Mixed directions in cascade are legal. Channel i advances in its own up_dn direction on any wrap of i-1.

## Timing
- Count, load and clear latency: 1 edge. The new q is visible after the edge.
- wrap rises in the same cycle q shows the wrapped value (0 for up, MAX_VAL for down) and falls after one cycle, unless another wrap occurs.
- ovf is visible 1 cycle after the wrap event.
- The cascade chain is fully combinational across CHANNELS stages. The critical path scales with CHANNELS*WIDTH.
- Reset takes effect on the first rising edge with rst low. All outputs are 0 at that edge, and there is no output activity until rst is high at an edge.
- Deasserting reset mid-count: counting resumes from 0 on the first edge with rst high and en set.

## Test plan
- Reset: rst low 2 cycles, en=all 1 → q=0, wrap=0, ovf=0. Release; 3 up edges on ch0 → q0=3.
- Up wrap, WIDTH=4, MAX_VAL=15: load ch0=14, then count up → 15, then 0 with wrap0=1 for one cycle, ovf0=1 sticky; ovf_clr0 → ovf0=0.
- Modulo/down, MAX_VAL=9: load_val=12 → q=9 (saturated); count down from 0 → 9 with wrap=1; count up from 9 → 0.
- Priority: clr, load(7) and en high together → q=0; load(7) with en high → q=7 (no increment); ovf_clr with a wrap in the same cycle → ovf stays 1.
- Cascade, CHANNELS=2, MAX_VAL=15: load ch0=15, ch1=3, count up → ch0=0, ch1=4 on the same edge, wrap0=1, wrap1=0. Load ch1=15 and ch0=15, count → both 0, wrap=2'b11.
- Independence, CASCADE=0: ch0 up and ch1 down concurrently for 20 edges from 0 → q0=4, q1=12, each wrap pulse counted once (ch0 once, ch1 twice).

Source files
------------

// File: rtl/counter_nch_if.sv
// counter_nch_if: control and status bundle for the counter_nch bank.
interface counter_nch_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2
);
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       up_dn;
  logic [CHANNELS-1:0]       clr;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] load_val;
  logic [CHANNELS-1:0]       ovf_clr;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0]       wrap;
  logic [CHANNELS-1:0]       ovf;

  modport master (
    output en, up_dn, clr, load, load_val, ovf_clr,
    input  q, wrap, ovf
  );

  modport slave (
    input  en, up_dn, clr, load, load_val, ovf_clr,
    output q, wrap, ovf
  );
endinterface

// File: rtl/counter_nch.sv
// counter_nch: bank of modulo counters with clear, load, wrap pulses,
// sticky overflow and an optional ripple cascade between channels.
module counter_nch #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit          CASCADE  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  counter_nch_if.slave  bus
);

  localparam int unsigned QW = CHANNELS * WIDTH;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic [QW-1:0]       q_r;
  logic [CHANNELS-1:0] wrap_r;
  logic [CHANNELS-1:0] ovf_r;

  logic [QW-1:0]       q_nxt_c;
  logic [CHANNELS-1:0] wrap_nxt_c;
  logic [CHANNELS-1:0] ovf_nxt_c;
  logic [CHANNELS-1:0] eff_c;
  logic [CHANNELS-1:0] wev_c;

  // Per-channel next state; the wrap event of each channel feeds the next one's enable in cascade mode.
  always_comb begin : next_c
    logic             prev;
    logic [WIDTH-1:0] q_cur;
    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] step;
    prev       = 1'b1;
    q_cur      = '0;
    lv         = '0;
    step       = '0;
    eff_c      = '0;
    wev_c      = '0;
    q_nxt_c    = q_r;
    wrap_nxt_c = '0;
    ovf_nxt_c  = ovf_r;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      q_cur    = q_r[i*WIDTH +: WIDTH];
      lv       = bus.load_val[i*WIDTH +: WIDTH];
      eff_c[i] = bus.en[i] & (CASCADE ? prev : 1'b1);
      if (bus.up_dn[i]) begin
        step = (q_cur == MAXV) ? '0 : q_cur + WIDTH'(1);
      end else begin
        step = (q_cur == '0) ? MAXV : q_cur - WIDTH'(1);
      end
      wev_c[i] = eff_c[i] & ~bus.clr[i] & ~bus.load[i] &
                 (bus.up_dn[i] ? (q_cur == MAXV) : (q_cur == '0));
      prev          = wev_c[i];
      wrap_nxt_c[i] = wev_c[i];
      if (bus.clr[i]) begin
        q_nxt_c[i*WIDTH +: WIDTH] = '0;
        ovf_nxt_c[i]              = 1'b0;
      end else if (bus.load[i]) begin
        q_nxt_c[i*WIDTH +: WIDTH] = (lv > MAXV) ? MAXV : lv;
        ovf_nxt_c[i]              = ovf_r[i] & ~bus.ovf_clr[i];
      end else begin
        if (eff_c[i]) begin
          q_nxt_c[i*WIDTH +: WIDTH] = step;
        end
        ovf_nxt_c[i] = wev_c[i] | (ovf_r[i] & ~bus.ovf_clr[i]);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r    <= '0;
      wrap_r <= '0;
      ovf_r  <= '0;
    end else begin
      q_r    <= q_nxt_c;
      wrap_r <= wrap_nxt_c;
      ovf_r  <= ovf_nxt_c;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_counter_nch.sv
// tb_counter_nch: three counter_nch configurations driven with common stimulus,
// checked from a vector table plus loop-built sequences through a scoreboard queue.
module tb_counter_nch;

  typedef struct {
    logic [1:0] sel;   // 0 base, 1 mod-10, 2 cascade, 3 all
    logic       rst;
    logic [1:0] en;
    logic [1:0] up_dn;
    logic [1:0] clr;
    logic [1:0] load;
    logic [7:0] lv;
    logic [1:0] oc;
    logic [7:0] eq;
    logic [1:0] ew;
    logic [1:0] eo;
    string      nm;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] en, up_dn, clr, load, ovf_clr;
  logic [7:0] load_val;

  int errors = 0;
  int checks = 0;
  vec_t sb[$];
  vec_t vt[$];

  counter_nch_if #(.WIDTH(4), .CHANNELS(2)) if_b ();
  counter_nch_if #(.WIDTH(4), .CHANNELS(2)) if_m ();
  counter_nch_if #(.WIDTH(4), .CHANNELS(2)) if_c ();

  assign if_b.en = en;  assign if_b.up_dn = up_dn;  assign if_b.clr = clr;
  assign if_b.load = load;  assign if_b.load_val = load_val;  assign if_b.ovf_clr = ovf_clr;
  assign if_m.en = en;  assign if_m.up_dn = up_dn;  assign if_m.clr = clr;
  assign if_m.load = load;  assign if_m.load_val = load_val;  assign if_m.ovf_clr = ovf_clr;
  assign if_c.en = en;  assign if_c.up_dn = up_dn;  assign if_c.clr = clr;
  assign if_c.load = load;  assign if_c.load_val = load_val;  assign if_c.ovf_clr = ovf_clr;

  counter_nch #(.WIDTH(4), .CHANNELS(2), .MAX_VAL(15), .CASCADE(1'b0))
    u_base (.clk(clk), .rst(rst), .bus(if_b.slave));
  counter_nch #(.WIDTH(4), .CHANNELS(2), .MAX_VAL(9), .CASCADE(1'b0))
    u_mod (.clk(clk), .rst(rst), .bus(if_m.slave));
  counter_nch #(.WIDTH(4), .CHANNELS(2), .MAX_VAL(15), .CASCADE(1'b1))
    u_cas (.clk(clk), .rst(rst), .bus(if_c.slave));

  logic [7:0] qo [3];
  logic [1:0] wo [3];
  logic [1:0] oo [3];
  assign qo[0] = if_b.q;  assign wo[0] = if_b.wrap;  assign oo[0] = if_b.ovf;
  assign qo[1] = if_m.q;  assign wo[1] = if_m.wrap;  assign oo[1] = if_m.ovf;
  assign qo[2] = if_c.q;  assign wo[2] = if_c.wrap;  assign oo[2] = if_c.ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] sel, logic r, logic [1:0] e, logic [1:0] u,
                              logic [1:0] c, logic [1:0] l, logic [7:0] lv, logic [1:0] oc,
                              logic [7:0] eq, logic [1:0] ew, logic [1:0] eo, string nm);
    vec_t v;
    v.sel = sel; v.rst = r; v.en = e; v.up_dn = u; v.clr = c; v.load = l;
    v.lv = lv; v.oc = oc; v.eq = eq; v.ew = ew; v.eo = eo; v.nm = nm;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; en = v.en; up_dn = v.up_dn; clr = v.clr;
    load = v.load; load_val = v.lv; ovf_clr = v.oc;
    sb.push_back(v);
  endtask

  task automatic chk(input string nm, input int d, input string fld,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d %s: got %h want %h", nm, d, fld, act, exp);
    end
  endtask

  // Scoreboard: each edge consumes the expectation pushed for the inputs applied before it.
  always @(posedge clk) begin
    vec_t cur;
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      for (int d = 0; d < 3; d++) begin
        if (cur.sel == 2'd3 || int'(cur.sel) == d) begin
          chk(cur.nm, d, "q",    qo[d],               cur.eq);
          chk(cur.nm, d, "wrap", {6'd0, wo[d]},       {6'd0, cur.ew});
          chk(cur.nm, d, "ovf",  {6'd0, oo[d]},       {6'd0, cur.eo});
        end
      end
    end
  end

  initial begin
    int q0, q1;
    rst = 1'b0; en = '0; up_dn = '0; clr = '0; load = '0; load_val = '0; ovf_clr = '0;

    // reset and basic up count
    vt.push_back(mk(3, 0, 2'b11, 2'b11, 0, 0, 8'h00, 0, 8'h00, 0, 0, "rst_a"));
    vt.push_back(mk(3, 0, 2'b11, 2'b11, 0, 0, 8'h00, 0, 8'h00, 0, 0, "rst_b"));
    vt.push_back(mk(3, 1, 2'b01, 2'b11, 0, 0, 8'h00, 0, 8'h01, 0, 0, "up1"));
    vt.push_back(mk(3, 1, 2'b01, 2'b11, 0, 0, 8'h00, 0, 8'h02, 0, 0, "up2"));
    vt.push_back(mk(3, 1, 2'b01, 2'b11, 0, 0, 8'h00, 0, 8'h03, 0, 0, "up3"));
    // up wrap and sticky overflow, full range
    vt.push_back(mk(0, 1, 2'b00, 2'b11, 0, 2'b01, 8'h0E, 0, 8'h0E, 0, 0, "load14"));
    vt.push_back(mk(0, 1, 2'b01, 2'b11, 0, 0, 8'h00, 0, 8'h0F, 0, 0, "up15"));
    vt.push_back(mk(0, 1, 2'b01, 2'b11, 0, 0, 8'h00, 0, 8'h00, 2'b01, 2'b01, "wrap_up"));
    vt.push_back(mk(0, 1, 2'b00, 2'b11, 0, 0, 8'h00, 0, 8'h00, 2'b00, 2'b01, "ovf_sticky"));
    vt.push_back(mk(0, 1, 2'b00, 2'b11, 0, 0, 8'h00, 2'b01, 8'h00, 0, 0, "ovf_clr"));
    // modulo-10 saturation and wrap both directions
    vt.push_back(mk(3, 1, 2'b00, 2'b11, 2'b11, 0, 8'h00, 0, 8'h00, 0, 0, "clr_all1"));
    vt.push_back(mk(1, 1, 2'b00, 2'b11, 0, 2'b01, 8'h0C, 0, 8'h09, 0, 0, "sat_load"));
    vt.push_back(mk(1, 1, 2'b00, 2'b11, 2'b01, 0, 8'h00, 0, 8'h00, 0, 0, "clr0"));
    vt.push_back(mk(1, 1, 2'b01, 2'b00, 0, 0, 8'h00, 0, 8'h09, 2'b01, 2'b01, "down_wrap"));
    vt.push_back(mk(1, 1, 2'b01, 2'b01, 0, 0, 8'h00, 0, 8'h00, 2'b01, 2'b01, "up_wrap9"));
    vt.push_back(mk(1, 1, 2'b00, 2'b11, 0, 2'b10, 8'hF0, 0, 8'h90, 0, 2'b01, "sat_load1"));
    // priority
    vt.push_back(mk(3, 1, 2'b00, 2'b11, 2'b11, 0, 8'h00, 0, 8'h00, 0, 0, "clr_all2"));
    vt.push_back(mk(0, 1, 2'b01, 2'b01, 2'b01, 2'b01, 8'h07, 0, 8'h00, 0, 0, "clr_over_load"));
    vt.push_back(mk(0, 1, 2'b01, 2'b01, 0, 2'b01, 8'h07, 0, 8'h07, 0, 0, "load_over_en"));
    vt.push_back(mk(0, 1, 2'b00, 2'b01, 0, 2'b01, 8'h0F, 0, 8'h0F, 0, 0, "load15"));
    vt.push_back(mk(0, 1, 2'b01, 2'b01, 0, 0, 8'h00, 2'b01, 8'h00, 2'b01, 2'b01, "set_wins"));
    vt.push_back(mk(0, 1, 2'b00, 2'b01, 0, 0, 8'h00, 2'b01, 8'h00, 0, 0, "ovf_clr2"));
    // cascade
    vt.push_back(mk(3, 1, 2'b00, 2'b11, 2'b11, 0, 8'h00, 0, 8'h00, 0, 0, "clr_all3"));
    vt.push_back(mk(2, 1, 2'b00, 2'b11, 0, 2'b11, 8'h3F, 0, 8'h3F, 0, 0, "cas_load"));
    vt.push_back(mk(2, 1, 2'b11, 2'b11, 0, 0, 8'h00, 0, 8'h40, 2'b01, 2'b01, "cas_carry"));
    vt.push_back(mk(2, 1, 2'b00, 2'b11, 0, 2'b11, 8'hFF, 0, 8'hFF, 0, 2'b01, "cas_loadff"));
    vt.push_back(mk(2, 1, 2'b11, 2'b11, 0, 0, 8'h00, 0, 8'h00, 2'b11, 2'b11, "cas_both"));
    vt.push_back(mk(2, 1, 2'b00, 2'b11, 0, 2'b01, 8'h0F, 0, 8'h0F, 0, 2'b11, "cas_load0"));
    vt.push_back(mk(2, 1, 2'b11, 2'b11, 0, 2'b01, 8'h0F, 0, 8'h0F, 0, 2'b11, "cas_suppress"));
    vt.push_back(mk(2, 1, 2'b11, 2'b11, 0, 0, 8'h00, 0, 8'h10, 2'b01, 2'b11, "cas_ripple"));
    vt.push_back(mk(2, 1, 2'b11, 2'b11, 0, 0, 8'h00, 0, 8'h11, 0, 2'b11, "cas_gate"));
    vt.push_back(mk(3, 1, 2'b00, 2'b11, 2'b11, 0, 8'h00, 0, 8'h00, 0, 0, "clr_all4"));

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);

    // independence: ch0 up, ch1 down for 20 edges from zero
    for (int k = 1; k <= 20; k++) begin
      q0 = k % 16;
      q1 = (16 - (k % 16)) % 16;
      apply(mk(0, 1, 2'b11, 2'b01, 0, 0, 8'h00, 0, {4'(q1), 4'(q0)},
               {1'(k % 16 == 1), 1'(k % 16 == 0)}, {1'b1, 1'(k >= 16)}, "indep"));
    end

    // reset mid-count overrides load, then counting resumes from zero
    apply(mk(3, 0, 2'b11, 2'b11, 0, 2'b11, 8'hFF, 0, 8'h00, 0, 0, "rst_mid"));
    apply(mk(3, 1, 2'b01, 2'b11, 0, 0, 8'h00, 0, 8'h01, 0, 0, "resume"));

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
